spi_reg_bank: RTL

//  SPI-mode-0..3 peripheral with a parametrised write/read register bank, successor of the fixed 16-bit write-only receiver.
//  - Clock domain: system clock. SCLK, COPI and nCS are oversampled via synchronisers.
//  - Feeds NUM_REGS control registers (PWM enables/duty, etc.) to the rest of the chip.
//  - Adds readback over CIPO, configurable CPOL/CPHA, and frame/address error reporting.

---
 rtl/spi_reg_bank.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// SPI peripheral (modes 0..3) with a small write/read register bank.
// SCLK, COPI and nCS are oversampled in the system clock domain. Frames are
// {rw, addr, data}, MSB first. Writes commit on nCS rise, and reads return
// the addressed register on CIPO during the data phase.
module spi_reg_bank #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_valid,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ADDR  = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   NREG      = (ADDR_W + 1)'(NUM_REGS);
  localparam logic              SAMPLE_RISE = (CPOL == CPHA);
  localparam logic              IDLE_SCLK   = (CPOL != 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise, sclk_fall, sample_edge, shift_edge;

  logic [CNT_W-1:0]       bit_cnt_q;
  logic [FRAME_W-1:0]     rx_shift_q;
  logic [DATA_W-1:0]      tx_shift_q;
  logic                   load_pend_q;
  logic                   tx_phase_q;

  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic                   wr_valid_q, frame_err_q;
  logic [ADDR_W-1:0]      wr_addr_q;

  logic                   start, commit_wr, commit_err;
  logic                   frame_rw, frame_full, addr_ok;
  logic [ADDR_W-1:0]      frame_addr, hdr_addr;
  logic [DATA_W-1:0]      frame_data, rd_data;

  // Input synchronisers, reset to the bus idle levels so reset makes no edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{IDLE_SCLK}};
      ncs_sync_q  <= {SYNC_STAGES{1'b1}};
      copi_sync_q <= '0;
      sclk_prev_q <= IDLE_SCLK;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s      = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

  assign frame_rw   = rx_shift_q[FRAME_W-1];
  assign frame_addr = rx_shift_q[FRAME_W-2 -: ADDR_W];
  assign frame_data = rx_shift_q[DATA_W-1:0];
  assign hdr_addr   = rx_shift_q[ADDR_W-1:0];
  assign frame_full = (bit_cnt_q == CNT_FULL);
  assign addr_ok    = ({1'b0, frame_addr} < NREG);

  // Readback mux; unimplemented addresses read as zero
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (hdr_addr == ADDR_W'(r)) rd_data = regs_q[r];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and one-cycle commit decisions
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    commit_wr  = 1'b0;
    commit_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Level test also catches a fall that arrived during COMMIT
        if (!ncs_s) begin
          state_d = S_SHIFT;
          start   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (ncs_s) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (frame_full && frame_rw && addr_ok) begin
          commit_wr = 1'b1;
        end else if ((bit_cnt_q != '0 && !frame_full) ||
                     (frame_full && frame_rw && !addr_ok)) begin
          commit_err = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit counter, receive shifter and transmit shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      load_pend_q <= 1'b0;
      tx_phase_q  <= 1'b0;
    end else if (start) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      load_pend_q <= 1'b0;
      tx_phase_q  <= 1'b0;
    end else if (state_q == S_SHIFT) begin
      // An edge coinciding with the nCS rise is still counted here
      if (sample_edge) begin
        rx_shift_q <= {rx_shift_q[FRAME_W-2:0], copi_s};
        if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + 1'b1;
        // Header completes on this edge; rw sits at bit ADDR_W-1 before the shift
        if (bit_cnt_q == CNT_ADDR && !rx_shift_q[ADDR_W-1]) load_pend_q <= 1'b1;
      end
      if (shift_edge) begin
        if (load_pend_q) begin
          tx_shift_q  <= rd_data;
          tx_phase_q  <= 1'b1;
          load_pend_q <= 1'b0;
        end else begin
          tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
    end else begin
      load_pend_q <= 1'b0;
      tx_phase_q  <= 1'b0;
    end
  end

  // Register bank update and write/error pulses, all taken from the COMMIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_valid_q  <= commit_wr;
      frame_err_q <= commit_err;
      if (commit_wr) begin
        wr_addr_q <= frame_addr;
        for (int r = 0; r < NUM_REGS; r++) begin
          if (frame_addr == ADDR_W'(r)) regs_q[r] <= frame_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo      = tx_phase_q & tx_shift_q[DATA_W-1];
  assign cipo_oe   = ~ncs_s;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
